// File: rtl/buffer_id_ex.sv
// ID/EX pipeline register for the FPU: operands, destination address, op flags, valid.
// Optional build macro IDEX_FLAG_CHECK_EN turns illegal flag patterns into flagged bubbles.
module buffer_id_ex #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] RLeftIn,
    input  logic [DSIZE-1:0] RRightIn,
    input  logic [ASIZE-1:0] RDAddressIn,
    input  logic [3:0]       FlagsIn,
    input  logic             ValidIn,
    input  logic             Stall,
    input  logic             Flush,
    output logic [DSIZE-1:0] RLeftOut,
    output logic [DSIZE-1:0] RRightOut,
    output logic [ASIZE-1:0] RDAddressOut,
    output logic [3:0]       FlagsOut,
    output logic             ValidOut,
    output logic             FlagErr
);

    logic [3:0] flagsCap;
    logic       validCap;
    logic       errCap;

`ifdef IDEX_FLAG_CHECK_EN
    logic flagsOneHot;
    logic flagsLegal;

    // An all-zero flag field is only acceptable on a bubble.
    always_comb begin
        flagsOneHot = (FlagsIn != 4'd0) && ((FlagsIn & (FlagsIn - 4'd1)) == 4'd0);
        flagsLegal  = flagsOneHot || ((FlagsIn == 4'd0) && !ValidIn);
        flagsCap    = flagsLegal ? FlagsIn : 4'd0;
        validCap    = flagsLegal ? ValidIn : 1'b0;
        errCap      = !flagsLegal;
    end
`else
    always_comb begin
        flagsCap = FlagsIn;
        validCap = ValidIn;
        errCap   = 1'b0;
    end
`endif

    // Flush outranks Stall so a stalled slot can still be squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RLeftOut     <= '0;
            RRightOut    <= '0;
            RDAddressOut <= '0;
            FlagsOut     <= '0;
            ValidOut     <= 1'b0;
            FlagErr      <= 1'b0;
        end else if (Flush) begin
            RLeftOut     <= '0;
            RRightOut    <= '0;
            RDAddressOut <= '0;
            FlagsOut     <= '0;
            ValidOut     <= 1'b0;
            FlagErr      <= 1'b0;
        end else if (!Stall) begin
            RLeftOut     <= RLeftIn;
            RRightOut    <= RRightIn;
            RDAddressOut <= RDAddressIn;
            FlagsOut     <= flagsCap;
            ValidOut     <= validCap;
            FlagErr      <= errCap;
        end
    end

endmodule

// File: tb/tb_buffer_id_ex.sv
// Scoreboard bench for buffer_id_ex: driver pushes model predictions, monitor pops and compares.
module tb_buffer_id_ex;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] RLeftIn = '0, RRightIn = '0;
    logic [4:0]  RDAddressIn = '0;
    logic [3:0]  FlagsIn = '0;
    logic        ValidIn = 1'b0, Stall = 1'b0, Flush = 1'b0;
    logic [31:0] RLeftOut, RRightOut;
    logic [4:0]  RDAddressOut;
    logic [3:0]  FlagsOut;
    logic        ValidOut, FlagErr;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [4:0]  a;
        logic [3:0]  f;
        logic        v;
        logic        e;
    } entry_t;

    entry_t expQ[$];
    entry_t model;
    int     nPass = 0;
    int     nTotal = 0;

    buffer_id_ex #(.DSIZE(32), .ASIZE(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .RLeftIn(RLeftIn), .RRightIn(RRightIn), .RDAddressIn(RDAddressIn),
        .FlagsIn(FlagsIn), .ValidIn(ValidIn), .Stall(Stall), .Flush(Flush),
        .RLeftOut(RLeftOut), .RRightOut(RRightOut), .RDAddressOut(RDAddressOut),
        .FlagsOut(FlagsOut), .ValidOut(ValidOut), .FlagErr(FlagErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic entry_t zeroEntry();
        entry_t z;
        z.l = '0; z.r = '0; z.a = '0; z.f = '0; z.v = 1'b0; z.e = 1'b0;
        return z;
    endfunction

    // What the EX side should hold after one edge, from the register's rules.
    function automatic entry_t predict(entry_t cur, logic [31:0] l, logic [31:0] r, logic [4:0] a,
                                       logic [3:0] f, logic v, logic s, logic fl);
        entry_t n;
        bit legal;
        if (fl) return zeroEntry();
        if (s) return cur;
        n.l = l; n.r = r; n.a = a; n.f = f; n.v = v; n.e = 1'b0;
        legal = ($countones(f) == 1) || (f == 4'd0 && !v);
`ifdef IDEX_FLAG_CHECK_EN
        if (!legal) begin
            n.f = 4'd0; n.v = 1'b0; n.e = 1'b1;
        end
`else
        legal = 1'b1;
`endif
        return n;
    endfunction

    task automatic step(input logic [31:0] l, input logic [31:0] r, input logic [4:0] a,
                        input logic [3:0] f, input logic v, input logic s, input logic fl);
        @(negedge clk);
        rst_n = 1'b1;
        RLeftIn = l; RRightIn = r; RDAddressIn = a; FlagsIn = f;
        ValidIn = v; Stall = s; Flush = fl;
        model = predict(model, l, r, a, f, v, s, fl);
        expQ.push_back(model);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".RLeftOut"}, RLeftOut, 32'd0);
        check({tag, ".RRightOut"}, RRightOut, 32'd0);
        check({tag, ".RDAddressOut"}, {27'd0, RDAddressOut}, 32'd0);
        check({tag, ".FlagsOut"}, {28'd0, FlagsOut}, 32'd0);
        check({tag, ".ValidOut"}, {31'd0, ValidOut}, 32'd0);
        check({tag, ".FlagErr"}, {31'd0, FlagErr}, 32'd0);
    endtask

    task automatic midReset();
        @(negedge clk);
        #2;
        RLeftIn = 32'hDEADBEEF; RRightIn = 32'h12345678; RDAddressIn = 5'd31;
        FlagsIn = 4'b0100; ValidIn = 1'b1; Stall = 1'b0; Flush = 1'b0;
        rst_n = 1'b0;
        #1;
        checkAllZero("asyncReset");
        model = zeroEntry();
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("heldReset");
    endtask

    // Monitor: compares every edge for which the driver issued a prediction.
    initial begin
        entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("RLeftOut", RLeftOut, e.l);
                check("RRightOut", RRightOut, e.r);
                check("RDAddressOut", {27'd0, RDAddressOut}, {27'd0, e.a});
                check("FlagsOut", {28'd0, FlagsOut}, {28'd0, e.f});
                check("ValidOut", {31'd0, ValidOut}, {31'd0, e.v});
                check("FlagErr", {31'd0, FlagErr}, {31'd0, e.e});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model = zeroEntry();
        RLeftIn = 32'hFFFF0001; RRightIn = 32'hA5A5A5A5; RDAddressIn = 5'd7;
        FlagsIn = 4'b0010; ValidIn = 1'b1;
        #2;
        checkAllZero("resetNoClock");
        repeat (2) @(posedge clk);

        // Release and capture on the first edge.
        step(32'hAFAB0000, 32'h0000AFAB, 5'd10, 4'b0001, 1'b1, 1'b0, 1'b0);
        // Stall for three edges with new inputs, then release.
        step(32'h11111111, 32'h22222222, 5'd3, 4'b0100, 1'b1, 1'b1, 1'b0);
        step(32'h33333333, 32'h44444444, 5'd4, 4'b1000, 1'b0, 1'b1, 1'b0);
        step(32'h55555555, 32'h66666666, 5'd5, 4'b0010, 1'b1, 1'b1, 1'b0);
        step(32'h77777777, 32'h88888888, 5'd6, 4'b0010, 1'b1, 1'b0, 1'b0);
        // Flush wins over stall.
        step(32'h99999999, 32'hAAAAAAAA, 5'd9, 4'b0001, 1'b1, 1'b1, 1'b1);
        step(32'h0BADF00D, 32'hCAFEF00D, 5'd12, 4'b0100, 1'b1, 1'b0, 1'b0);
        // Illegal and legal flag patterns.
        step(32'h01234567, 32'h89ABCDEF, 5'd17, 4'b0101, 1'b1, 1'b0, 1'b0);
        step(32'h01234567, 32'h89ABCDEF, 5'd17, 4'b0101, 1'b1, 1'b1, 1'b0);
        step(32'hFEDCBA98, 32'h76543210, 5'd18, 4'b1000, 1'b1, 1'b0, 1'b0);
        step(32'h00000001, 32'h00000002, 5'd1, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(32'h00000003, 32'h00000004, 5'd2, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(32'h00000005, 32'h00000006, 5'd3, 4'b1111, 1'b0, 1'b0, 1'b0);
        step(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 4'b0010, 1'b1, 1'b0, 1'b0);

        midReset();

        for (int i = 0; i < 400; i++) begin
            logic [3:0] f;
            if ($urandom_range(0, 9) < 7) f = 4'b0001 << $urandom_range(0, 3);
            else f = 4'($urandom_range(0, 15));
            step($urandom, $urandom, 5'($urandom_range(0, 31)), f,
                 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 2),
                 1'($urandom_range(0, 9) < 1));
            if (i == 200) midReset();
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboardDrained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
